// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch and data access.
// Data wins ties, a streak limiter protects fetch, and a watchdog bounds every access.
module mem_port_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int TIMEOUT      = 15,
  parameter int MAX_D_STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          stall,
  output logic          err,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] G_NONE  = 2'd0;
  localparam logic [1:0] G_FETCH = 2'd1;
  localparam logic [1:0] G_DATA  = 2'd2;

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [WW-1:0] WDOG_LIMIT = WW'(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_ready_q, if_ready_d;
  logic          d_ready_q, d_ready_d;
  logic          err_q, err_d;

  logic          grant_data;
  logic          grant_fetch;
  logic [WW-1:0] wdog_inc;
  logic          finish_busy;
  logic [DW-1:0] result_data;

  // Fetch may only be overtaken MAX_D_STREAK times in a row while it waits.
  assign grant_data  = d_req && (!if_req || (streak_q < STREAK_MAX));
  assign grant_fetch = !grant_data && if_req;
  assign wdog_inc    = wdog_q + WW'(1);
  assign finish_busy = m_ack || (wdog_inc == WDOG_LIMIT);
  assign result_data = m_ack ? m_rdata : '0;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    streak_d   = streak_q;
    wdog_d     = wdog_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (grant_data || grant_fetch) begin
          state_d   = S_BUSY;
          grant_d   = grant_data ? G_DATA : G_FETCH;
          m_req_d   = 1'b1;
          m_we_d    = grant_data && d_we;
          m_addr_d  = grant_data ? d_addr : if_addr;
          m_wdata_d = d_wdata;
          wdog_d    = '0;
          if (grant_data && if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end
      end

      S_BUSY: begin
        wdog_d = wdog_inc;
        if (finish_busy) begin
          state_d = S_DONE;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          if (!m_ack) begin
            err_d = 1'b1;
          end
          if (grant_q == G_FETCH) begin
            if_rdata_d = result_data;
            if_ready_d = 1'b1;
          end else begin
            // A write completion leaves the last read data visible.
            if (!m_we_q) begin
              d_rdata_d = result_data;
            end
            d_ready_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
      end

      default: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      grant_q    <= G_NONE;
      streak_q   <= '0;
      wdog_q     <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      streak_q   <= streak_d;
      wdog_q     <= wdog_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
      err_q      <= err_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign if_ready = if_ready_q;
  assign d_ready  = d_ready_q;
  assign err      = err_q;
  assign stall    = (if_req && !if_ready_q) || (d_req && !d_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter; the bench also plays the memory.
// Expected values come from a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;
  localparam int MAX_D_STREAK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          stall;
  logic          err;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            mdl_streak;
  bit            mdl_err;
  logic [DW-1:0] mdl_if_rdata;
  logic [DW-1:0] mdl_d_rdata;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .MAX_D_STREAK(MAX_D_STREAK)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .stall(stall), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic new_fetch();
    if_req  = 1'b1;
    if_addr = AW'($urandom);
  endtask

  task automatic new_data();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = AW'($urandom);
    d_wdata = $urandom;
  endtask

  // Runs one access from its IDLE cycle to its DONE cycle. w = memory wait
  // states before ack; w >= TIMEOUT means the memory never answers.
  // gnt: 0 none, 1 fetch, 2 data. oa: m_addr seen in the first BUSY cycle.
  task automatic run_txn(input int w, input bit use_val, input logic [31:0] ack_val,
                         output int gnt, output logic [AW-1:0] oa);
    bit            gd;
    bit            acked;
    int            nb;
    logic [31:0]   ackd;
    logic [AW-1:0] ea;
    bit            ewe;
    logic [31:0]   ewd;
    gnt  = 0;
    oa   = '0;
    ackd = '0;
    m_ack   = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
    if (!if_req && !d_req) begin
      @(negedge clk);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_m_req", 32'(m_req), 32'd0);
      next_cycle();
      return;
    end
    gd  = d_req && (!if_req || mdl_streak < MAX_D_STREAK);
    gnt = gd ? 2 : 1;
    ea  = gd ? d_addr : if_addr;
    ewe = gd && d_we;
    ewd = d_wdata;
    if (gd && if_req) mdl_streak = (mdl_streak + 1 > MAX_D_STREAK) ? MAX_D_STREAK : mdl_streak + 1;
    else mdl_streak = 0;

    @(negedge clk);
    chk("c0_stall", 32'(stall), 32'd1);
    chk("c0_m_req", 32'(m_req), 32'd0);
    chk("c0_ready", {30'd0, if_ready, d_ready}, 32'd0);
    next_cycle();

    acked = (w < TIMEOUT);
    nb    = acked ? w + 1 : TIMEOUT;
    for (int c = 1; c <= nb; c++) begin
      m_ack   = acked && (c == nb);
      m_rdata = use_val ? ack_val : $urandom;
      if (m_ack) ackd = m_rdata;
      @(negedge clk);
      chk("busy_m_req", 32'(m_req), 32'd1);
      chk("busy_m_addr", 32'(m_addr), 32'(ea));
      chk("busy_m_we", 32'(m_we), 32'(ewe));
      if (ewe) chk("busy_m_wdata", m_wdata, ewd);
      chk("busy_ready", {30'd0, if_ready, d_ready}, 32'd0);
      chk("busy_stall", 32'(stall), 32'd1);
      if (c == 1) oa = m_addr;
      next_cycle();
    end

    if (!acked) mdl_err = 1'b1;
    if (gd) begin
      if (!ewe) mdl_d_rdata = ackd;
    end else begin
      mdl_if_rdata = ackd;
    end

    m_ack   = 1'($urandom_range(0, 1));
    m_rdata = $urandom;
    @(negedge clk);
    chk("done_if_ready", 32'(if_ready), 32'(!gd));
    chk("done_d_ready", 32'(d_ready), 32'(gd));
    chk("done_m_req", 32'(m_req), 32'd0);
    chk("done_if_rdata", if_rdata, mdl_if_rdata);
    chk("done_d_rdata", d_rdata, mdl_d_rdata);
    chk("done_err", 32'(err), 32'(mdl_err));
    chk("done_stall", 32'(stall), 32'((if_req && gd) || (d_req && !gd)));
    next_cycle();
  endtask

  initial begin
    int            gnt;
    logic [AW-1:0] oa;
    int            w;
    int            r;
    logic [AW-1:0] exp_order [6];

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_rdata = '0; m_ack = 1'b0;
    mdl_streak = 0; mdl_err = 1'b0; mdl_if_rdata = '0; mdl_d_rdata = '0;

    // Reset values
    next_cycle();
    @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("rst_rdata", if_rdata | d_rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Data read, ack in the first BUSY cycle
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010; d_wdata = 32'h0;
    run_txn(0, 1'b1, 32'hDEADBEEF, gnt, oa);
    d_req = 1'b0;
    chk("dread_rdata", d_rdata, 32'hDEADBEEF);
    chk("dread_gnt", 32'(oa), 32'h010);

    // Fetch with three wait states
    if_req = 1'b1; if_addr = 10'h004;
    run_txn(3, 1'b1, 32'h8C010000, gnt, oa);
    if_req = 1'b0;
    chk("fetch_rdata", if_rdata, 32'h8C010000);

    // Simultaneous requests: data write first, then fetch
    if_req = 1'b1; if_addr = 10'h020;
    d_req = 1'b1; d_we = 1'b1; d_addr = 10'h030; d_wdata = 32'h12345678;
    run_txn(1, 1'b0, 32'h0, gnt, oa);
    chk("simul_first_addr", 32'(oa), 32'h030);
    d_req = 1'b0; d_we = 1'b0;
    run_txn(0, 1'b0, 32'h0, gnt, oa);
    chk("simul_second_addr", 32'(oa), 32'h020);
    chk("simul_d_rdata_kept", d_rdata, 32'hDEADBEEF);
    if_req = 1'b0;

    // Watchdog: memory never answers a data read
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h0AA;
    run_txn(TIMEOUT, 1'b0, 32'h0, gnt, oa);
    d_req = 1'b0;
    @(negedge clk);
    chk("wdog_err_sticky", 32'(err), 32'd1);
    chk("wdog_d_rdata", d_rdata, 32'd0);
    next_cycle();

    // Reset during the second BUSY cycle, late ack afterwards
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h055; m_ack = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("rbusy_m_req1", 32'(m_req), 32'd1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; d_req = 1'b0; m_ack = 1'b1; m_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("rbusy_m_req", 32'(m_req), 32'd0);
    chk("rbusy_ready", {30'd0, if_ready, d_ready}, 32'd0);
    chk("rbusy_err", 32'(err), 32'd0);
    chk("rbusy_d_rdata", d_rdata, 32'd0);
    next_cycle();
    m_ack = 1'b0;
    @(negedge clk);
    chk("rbusy_m_req_late", 32'(m_req), 32'd0);
    chk("rbusy_ready_late", {30'd0, if_ready, d_ready}, 32'd0);
    next_cycle();
    mdl_streak = 0; mdl_err = 1'b0; mdl_if_rdata = '0; mdl_d_rdata = '0;

    // Starvation: both held high, expect D,D,D,D,F,D (streak starts at 0 after reset)
    exp_order = '{10'h200, 10'h200, 10'h200, 10'h200, 10'h100, 10'h200};
    if_req = 1'b1; if_addr = 10'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 10'h200;
    for (int i = 0; i < 6; i++) begin
      run_txn(0, 1'b0, 32'h0, gnt, oa);
      chk($sformatf("starve_grant%0d", i), 32'(oa), 32'(exp_order[i]));
    end
    if_req = 1'b0; d_req = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      w = (r < 8) ? $urandom_range(0, 3) : (r == 8) ? $urandom_range(4, TIMEOUT - 1) : TIMEOUT;
      run_txn(w, 1'b0, 32'h0, gnt, oa);
      if (gnt == 2) begin
        if ($urandom_range(0, 1) == 1) new_data(); else d_req = 1'b0;
      end else if (gnt == 1) begin
        if ($urandom_range(0, 1) == 1) new_fetch(); else if_req = 1'b0;
      end else begin
        if ($urandom_range(0, 3) != 0) new_fetch();
        if ($urandom_range(0, 3) != 0) new_data();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
